// File: rtl/seven_seg_reader.sv
// seven_seg_reader: recovers the hex codes shown on a time-multiplexed
// 7-segment bus. Each digit dwell must be stable for STABLE_CYCLES registered
// samples before it is decoded into a slot of a working buffer. Once every
// slot has been captured, the buffer is published as one frame with a
// single-cycle frame_valid pulse.
module seven_seg_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     digit_sel,
  output logic [4*DIGITS-1:0]   value,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [DIGITS-1:0]     digit_err
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_CAPTURE,
    ST_HELD
  } state_t;

  // Pattern (g..a) to {illegal, nibble}. Unknown patterns, blank included,
  // decode to nibble 0 with the illegal flag set.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h3F:   r = 5'h00;
      7'h06:   r = 5'h01;
      7'h5B:   r = 5'h02;
      7'h4F:   r = 5'h03;
      7'h66:   r = 5'h04;
      7'h6D:   r = 5'h05;
      7'h7D:   r = 5'h06;
      7'h07:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h67:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h7C:   r = 5'h0B;
      7'h39:   r = 5'h0C;
      7'h5E:   r = 5'h0D;
      7'h79:   r = 5'h0E;
      7'h71:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  // Input stage and the sample before it, used for change detection
  logic [6:0]        s_seg_q, prev_seg_q;
  logic [DIGITS-1:0] s_sel_q, prev_sel_q;

  // Dwell tracking
  state_t            state_q;
  logic [7:0]        cnt_q, cnt_d;
  logic              sel_ok;
  logic              changed;
  logic              capture_go;
  logic [4:0]        dec;

  // Working buffer
  logic [4*DIGITS-1:0] work_nib_q, work_nib_d;
  logic [DIGITS-1:0]   work_err_q, work_err_d;
  logic [DIGITS-1:0]   captured_q, captured_d;
  logic                frame_done;

  // Published frame
  logic [4*DIGITS-1:0] value_q;
  logic [DIGITS-1:0]   digit_err_q;
  logic                frame_err_q;
  logic                frame_valid_q;

  assign sel_ok     = $onehot(s_sel_q);
  assign changed    = (s_seg_q != prev_seg_q) || (s_sel_q != prev_sel_q);
  assign dec        = decode_seg(s_seg_q);
  assign capture_go = sel_ok && (state_q == ST_WAIT) && (cnt_d == CNT_MAX);
  assign frame_done = &captured_q;

  // Register the bus once and keep the previous registered sample
  always_ff @(posedge clk) begin
    if (!reset) begin
      s_seg_q    <= '0;
      s_sel_q    <= '0;
      prev_seg_q <= '0;
      prev_sel_q <= '0;
    end else begin
      s_seg_q    <= seg_in;
      s_sel_q    <= digit_sel;
      prev_seg_q <= s_seg_q;
      prev_sel_q <= s_sel_q;
    end
  end

  // Dwell counter: run length of identical valid samples, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (!sel_ok) begin
      cnt_d = 8'd0;
    end else if ((cnt_q == 8'd0) || changed) begin
      cnt_d = 8'd1;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Dwell FSM: one capture per stable dwell, re-armed by any bus change
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_WAIT;
      cnt_q   <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        ST_WAIT: begin
          if (capture_go) state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (!sel_ok || changed) state_q <= ST_WAIT;
          else                    state_q <= ST_HELD;
        end
        ST_HELD: begin
          if (!sel_ok || changed) state_q <= ST_WAIT;
        end
        default: state_q <= ST_WAIT;
      endcase
    end
  end

  // Next working-buffer contents: clear the mask on completion, then merge
  // any capture so a same-cycle capture is never lost
  always_comb begin
    work_nib_d = work_nib_q;
    work_err_d = work_err_q;
    captured_d = frame_done ? '0 : captured_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (capture_go && s_sel_q[i]) begin
        work_nib_d[4*i +: 4] = dec[3:0];
        work_err_d[i]        = dec[4];
        captured_d[i]        = 1'b1;
      end
    end
  end

  // Working buffer and captured mask
  always_ff @(posedge clk) begin
    if (!reset) begin
      work_nib_q <= '0;
      work_err_q <= '0;
      captured_q <= '0;
    end else begin
      work_nib_q <= work_nib_d;
      work_err_q <= work_err_d;
      captured_q <= captured_d;
    end
  end

  // Publish the frame the cycle after the mask fills
  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q       <= '0;
      digit_err_q   <= '0;
      frame_err_q   <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= frame_done;
      if (frame_done) begin
        value_q     <= work_nib_q;
        digit_err_q <= work_err_q;
        frame_err_q <= |work_err_q;
      end
    end
  end

  assign value       = value_q;
  assign digit_err   = digit_err_q;
  assign frame_err   = frame_err_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Bench for seven_seg_reader: directed sequences, a decode table and random
// bus traffic, all checked against a cycle-level reference built from
// sample history.
module tb_seven_seg_reader;

  localparam int DIGITS = 4;
  localparam int S      = 4;

  localparam logic [6:0] PATS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic [3:0]  digit_sel;
  logic [15:0] value;
  logic        frame_valid;
  logic        frame_err;
  logic [3:0]  digit_err;

  seven_seg_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk(clk),
    .reset(reset),
    .seg_in(seg_in),
    .digit_sel(digit_sel),
    .value(value),
    .frame_valid(frame_valid),
    .frame_err(frame_err),
    .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int          frames_seen = 0;
  logic [15:0] last_val  = '0;
  logic [3:0]  last_derr = '0;
  logic        last_ferr = 1'b0;
  logic        prev_fv   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [10:0] hist[$];
  logic [15:0] m_nib  = '0;
  logic [3:0]  m_err  = '0;
  logic [3:0]  m_capt = '0;
  logic [15:0] m_val  = '0;
  logic [3:0]  m_derr = '0;
  logic        m_ferr = 1'b0;
  logic        m_fv   = 1'b0;
  bit          model_on  = 1'b0;
  bit          have_pend = 1'b0;
  logic [6:0]  p_seg;
  logic [3:0]  p_sel;
  logic        p_rst;

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      if (PATS[i] == p) return {1'b0, 4'(i)};
    end
    return 5'h10;
  endfunction

  // Length of the run of identical valid samples ending at the newest one
  function automatic int run_len();
    logic [10:0] last;
    int n;
    if (hist.size() == 0) return 0;
    last = hist[hist.size()-1];
    if ($countones(last[3:0]) != 1) return 0;
    n = 0;
    for (int i = hist.size()-1; i >= 0; i--) begin
      if (hist[i] == last) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_edge();
    logic [10:0] last;
    logic [4:0]  d;
    if (!p_rst) begin
      m_nib = '0; m_err = '0; m_capt = '0;
      m_val = '0; m_derr = '0; m_ferr = 1'b0; m_fv = 1'b0;
      hist.delete();
      hist.push_back(11'h0);
      model_on = 1'b1;
    end else begin
      m_fv = 1'b0;
      if (m_capt == 4'hF) begin
        m_val  = m_nib;
        m_derr = m_err;
        m_ferr = |m_err;
        m_fv   = 1'b1;
        m_capt = '0;
      end
      if (run_len() == S) begin
        last = hist[hist.size()-1];
        d = ref_decode(last[10:4]);
        for (int i = 0; i < DIGITS; i++) begin
          if (last[i]) begin
            m_nib[4*i +: 4] = d[3:0];
            m_err[i]        = d[4];
            m_capt[i]       = 1'b1;
          end
        end
      end
      hist.push_back({p_seg, p_sel});
      if (hist.size() > S + 2) void'(hist.pop_front());
    end
  endtask

  // Per-cycle monitor: advance the model by the edge just past, compare,
  // and record published frames
  initial begin
    forever begin
      @(negedge clk);
      if (have_pend) begin
        model_edge();
        if (model_on)
          check("cycle", {10'b0, frame_valid, frame_err, digit_err, value},
                         {10'b0, m_fv, m_ferr, m_derr, m_val});
      end
      if (frame_valid === 1'b1) begin
        check("fv_back_to_back", {31'b0, prev_fv}, 32'd0);
        frames_seen++;
        last_val  = value;
        last_derr = digit_err;
        last_ferr = frame_err;
      end
      prev_fv   = frame_valid;
      p_seg     = seg_in;
      p_sel     = digit_sel;
      p_rst     = reset;
      have_pend = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
    seg_in    = s;
    digit_sel = d;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3,
                       input int n, input bit reverse);
    if (!reverse) begin
      hold(p0, 4'b0001, n); hold(p1, 4'b0010, n);
      hold(p2, 4'b0100, n); hold(p3, 4'b1000, n);
    end else begin
      hold(p3, 4'b1000, n); hold(p2, 4'b0100, n);
      hold(p1, 4'b0010, n); hold(p0, 4'b0001, n);
    end
    hold(7'h00, 4'b0000, 3);
  endtask

  typedef struct {
    logic [6:0] pat;
    logic [3:0] nib;
    logic       err;
  } vec_t;

  vec_t vt [20];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int f0;
    logic [6:0] rs;
    logic [3:0] rd;

    vt[0]  = '{7'h3F, 4'h0, 1'b0};  vt[1]  = '{7'h06, 4'h1, 1'b0};
    vt[2]  = '{7'h5B, 4'h2, 1'b0};  vt[3]  = '{7'h4F, 4'h3, 1'b0};
    vt[4]  = '{7'h66, 4'h4, 1'b0};  vt[5]  = '{7'h6D, 4'h5, 1'b0};
    vt[6]  = '{7'h7D, 4'h6, 1'b0};  vt[7]  = '{7'h07, 4'h7, 1'b0};
    vt[8]  = '{7'h7F, 4'h8, 1'b0};  vt[9]  = '{7'h67, 4'h9, 1'b0};
    vt[10] = '{7'h77, 4'hA, 1'b0};  vt[11] = '{7'h7C, 4'hB, 1'b0};
    vt[12] = '{7'h39, 4'hC, 1'b0};  vt[13] = '{7'h5E, 4'hD, 1'b0};
    vt[14] = '{7'h79, 4'hE, 1'b0};  vt[15] = '{7'h71, 4'hF, 1'b0};
    vt[16] = '{7'h00, 4'h0, 1'b1};  vt[17] = '{7'h7E, 4'h0, 1'b1};
    vt[18] = '{7'h08, 4'h0, 1'b1};  vt[19] = '{7'h7B, 4'h0, 1'b1};

    // Reset and idle
    reset = 1'b0;
    hold(7'h7F, 4'b0001, 3);
    check("reset_outputs", {10'b0, frame_valid, frame_err, digit_err, value}, 32'd0);
    reset = 1'b1;
    hold(7'h7F, 4'b0000, 20);
    check("idle_frames", frames_seen, 0);

    // Clean frame
    f0 = frames_seen;
    scan4(7'h4F, 7'h5B, 7'h06, 7'h3F, 8, 1'b0);
    check("clean_count", frames_seen, f0 + 1);
    check("clean_value", last_val, 16'h0123);
    check("clean_err", {last_ferr, last_derr}, 5'b0_0000);

    // Glitch rejection on digit 1
    f0 = frames_seen;
    hold(7'h3F, 4'b0001, 8);
    hold(7'h6D, 4'b0010, 3);
    hold(7'h66, 4'b0010, 6);
    hold(7'h5B, 4'b0100, 8);
    hold(7'h4F, 4'b1000, 8);
    hold(7'h00, 4'b0000, 3);
    check("glitch_count", frames_seen, f0 + 1);
    check("glitch_value", last_val, 16'h3240);

    // Illegal (blank) pattern on digit 2
    f0 = frames_seen;
    scan4(7'h7C, 7'h7C, 7'h00, 7'h7C, 8, 1'b0);
    check("illegal_count", frames_seen, f0 + 1);
    check("illegal_value", last_val, 16'hB0BB);
    check("illegal_derr", last_derr, 4'b0100);
    check("illegal_ferr", last_ferr, 1'b1);

    // Multi-hot select captures nothing
    f0 = frames_seen;
    hold(7'h06, 4'b0011, 10);
    check("badsel_none", frames_seen, f0);
    hold(7'h66, 4'b0001, 8);
    hold(7'h7D, 4'b0010, 8);
    hold(7'h07, 4'b0100, 8);
    hold(7'h00, 4'b0000, 3);
    check("badsel_partial", frames_seen, f0);
    hold(7'h7F, 4'b1000, 8);
    hold(7'h00, 4'b0000, 3);
    check("badsel_count", frames_seen, f0 + 1);
    check("badsel_value", last_val, 16'h8764);

    // Reset mid-frame discards partial captures
    f0 = frames_seen;
    hold(7'h06, 4'b0001, 8);
    hold(7'h06, 4'b0010, 8);
    reset = 1'b0;
    hold(7'h00, 4'b0000, 1);
    reset = 1'b1;
    hold(7'h71, 4'b0100, 8);
    hold(7'h71, 4'b1000, 8);
    hold(7'h00, 4'b0000, 3);
    check("rst_partial", frames_seen, f0);
    hold(7'h71, 4'b0001, 8);
    hold(7'h71, 4'b0010, 8);
    hold(7'h00, 4'b0000, 3);
    check("rst_count", frames_seen, f0 + 1);
    check("rst_value", last_val, 16'hFFFF);

    // Dwell one short of the threshold is ignored; exactly the threshold captures
    f0 = frames_seen;
    scan4(7'h07, 7'h07, 7'h07, 7'h07, S - 1, 1'b0);
    check("short_dwell", frames_seen, f0);
    scan4(7'h7F, 7'h67, 7'h77, 7'h39, S, 1'b0);
    check("exact_count", frames_seen, f0 + 1);
    check("exact_value", last_val, 16'hCA98);

    // Re-capture of a slot overwrites it
    f0 = frames_seen;
    hold(7'h06, 4'b0001, 6);
    hold(7'h5B, 4'b0001, 6);
    hold(7'h4F, 4'b0010, 6);
    hold(7'h66, 4'b0100, 6);
    hold(7'h6D, 4'b1000, 6);
    hold(7'h00, 4'b0000, 3);
    check("recap_count", frames_seen, f0 + 1);
    check("recap_value", last_val, 16'h5432);

    // Decode table
    for (int j = 0; j < 20; j++) begin
      f0 = frames_seen;
      scan4(vt[j].pat, vt[j].pat, vt[j].pat, vt[j].pat, 5, j[0]);
      check("tbl_count", frames_seen, f0 + 1);
      check("tbl_frame", {last_ferr, last_derr, last_val},
                         {vt[j].err, {4{vt[j].err}}, {4{vt[j].nib}}});
    end

    // Random traffic, checked cycle by cycle against the model
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b0;
        hold(seg_in, digit_sel, 1);
        reset = 1'b1;
      end
      if ($urandom_range(0, 9) < 8) rd = 4'(1 << $urandom_range(0, 3));
      else                          rd = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 8) rs = vt[$urandom_range(0, 15)].pat;
      else                          rs = 7'($urandom_range(0, 127));
      hold(rs, rd, $urandom_range(1, 9));
    end
    hold(7'h00, 4'b0000, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_reader.md
# seven_seg_reader

Receive-side counterpart of the segment decoder: observes a time-multiplexed 7-segment bus (active-high segment lines plus one-hot digit select) and recovers the 4-bit code shown on each digit. It registers the bus and waits for each digit's dwell to be stable. It then maps the pattern back to a nibble and assembles a full multi-digit frame with a one-cycle valid pulse. It is used in self-checking display paths and board-level loopback, after the display scan driver.

## Interface
- DIGITS, 4, number of multiplexed digits; frame width is 4*DIGITS.
- STABLE_CYCLES, 4, consecutive identical registered samples needed before a digit is captured; legal range 2..255.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- seg_in  in  7  segment lines, bit0=a, bit1=b … bit6=g, 1 = segment lit.
- digit_sel  in  DIGITS  one-hot digit select from the scan driver; bit i = digit i.
- value  out  4*DIGITS  last complete frame; digit i in value[4i+3:4i].
- frame_valid  out  1  one-cycle pulse when value/frame_err update.
- frame_err  out  1  at least one digit in the frame held an illegal pattern.
- digit_err  out  DIGITS  per-digit illegal-pattern flags for the frame.

## Operation
- Input stage: seg_in and digit_sel are registered once (s_seg, s_sel). All decisions use the registered copies.
- Valid select: s_sel has exactly one bit set. Zero or multiple bits set forces state WAIT, clears the dwell counter, and captures nothing.
- Dwell counter (8 bit): the counter is 1 on the first valid-select sample. It increments while s_seg and s_sel equal the previous registered sample. It resets to 1 on any change. It saturates at STABLE_CYCLES.
- FSM:
  - WAIT → CAPTURE when the counter reaches STABLE_CYCLES.
  - CAPTURE lasts one cycle, then goes to HELD.
  - HELD → WAIT on any change of s_seg or s_sel.
  - Exactly one capture per dwell.
- Decode (pattern g..a in hex → nibble): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 67→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
  - Any other pattern, including blank 00, is illegal: the nibble is stored as 0 and the slot error bit is set.
- Capture writes the nibble and error bit into slot i (the one-hot index of s_sel) of a working buffer and sets captured[i].
  - Re-capture of a slot already captured overwrites its nibble and error bit; captured is unchanged.
- Frame completion: when captured becomes all-ones, on the next cycle:
  - value ← working nibbles.
  - digit_err ← working error bits.
  - frame_err ← OR of the error bits.
  - frame_valid = 1.
  - captured ← 0.
- Working buffer contents persist between frames; only the captured mask clears.
- Digits may arrive in any order.

## Timing
- Reset values: value=0, digit_err=0, frame_err=0, frame_valid=0. Internally: FSM=WAIT, counter=0, captured=0, working buffer=0, s_seg=0, s_sel=0.
- Reset asserted mid-dwell or mid-frame discards partial captures. Reset wins over a simultaneous capture or frame completion.
- Capture latency: a bus value first driven before edge k is registered at edge k. The capture write occurs at edge k+STABLE_CYCLES.
- Frame latency: frame_valid is high for the single cycle after the edge that completes captured. value is stable from that cycle until the next frame.
- A dwell shorter than STABLE_CYCLES registered samples is ignored.
- Capture of the last slot and a bus change in the same cycle: the capture still completes and the FSM returns to WAIT.
- frame_valid never asserts on two consecutive cycles when DIGITS ≥ 2.

## Test plan
- Reset/idle: hold reset=0 for 3 cycles with seg_in=7F, digit_sel=0001 → all outputs 0, no frame_valid for 20 cycles after release with digit_sel=0.
- Clean frame: STABLE_CYCLES=4; scan digits 0..3 with patterns 4F, 5B, 06, 3F, dwell 8 cycles each → one frame_valid pulse, value=16'h0123, frame_err=0, digit_err=0000.
- Glitch rejection: digit 1 shows 6D for 3 cycles then 66 for 6 cycles; other digits legal → digit 1 nibble = 4, no capture of 5.
- Illegal pattern: digit 2 shows 00 (blank), others show 7C → value=16'hB0BB, digit_err=0100, frame_err=1.
- Bad select: digit_sel=0011 for 10 cycles, then normal scan → nothing captured during the 0011 period; frame completes only after all four valid dwells.
- Reset mid-frame: capture digits 0 and 1, assert reset one cycle, then scan all four with 71 → single frame value=16'hFFFF; no frame from the pre-reset partial data.
